sr_mdu_issue: RTL and testbench
===============================

SR_MDU_ISSUE -- requirements
Module: sr_mdu_issue

Interface
REQ-001 SHALL have parameter: max_wait, 16, max cycles from mdu_vld to mdu_o_vld before timeout (legal 2..255).
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports from CPU decode: req input 1 (current instr is MUL); rd input 5 (dest reg); srcA, srcB input 32 each (register operands).
REQ-005 SHALL have port: stall  output  1  hold PC/decode while high.
REQ-006 SHALL have ports to register file: wb_en output 1; wb_addr output 5; wb_data output 32.
REQ-007 SHALL have ports to multiplier: mdu_vld output 1; mdu_srcA, mdu_srcB output 32 each; mdu_o_vld input 1; mdu_result input 32; mdu_busy input 1.
REQ-008 SHALL have port: err  output  1  sticky timeout flag.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, WB; one-hot or binary at implementer's choice.
REQ-010 IDLE: req=1 -> latch rd, srcA, srcB into internal registers; next state ISSUE; req=0 -> stay.
REQ-011 ISSUE: mdu_busy=0 -> mdu_vld=1 this cycle, clear wait counter, next WAIT; mdu_busy=1 -> mdu_vld=0, stay.
REQ-012 mdu_vld SHALL be high only in ISSUE with mdu_busy=0; exactly one pulse per accepted req.
REQ-013 mdu_srcA/mdu_srcB SHALL drive the latched operands, stable from ISSUE entry until next IDLE acceptance.
REQ-014 WAIT: mdu_o_vld=1 -> capture mdu_result into wb_data register, next WB; otherwise increment 8-bit wait counter.
REQ-015 WB: wb_en=1 for exactly one cycle unless latched rd==0 or timeout occurred; wb_addr = latched rd; next IDLE.
REQ-016 stall SHALL equal (IDLE and req) or ISSUE or WAIT; stall=0 in WB so CPU retires the MUL that cycle.
REQ-017 The req still high during WB SHALL NOT cause re-issue (FSM not in IDLE).
REQ-018 mdu_o_vld in IDLE, ISSUE or WB SHALL be ignored (no capture, no state change).
REQ-019 Minimum MDU latency is 1 cycle; earliest WB = issue cycle + 2.
REQ-020 wb_data SHALL hold last captured value outside WB; wb_addr holds latched rd.

Reset
REQ-021 rst=0 SHALL immediately force: state IDLE, stall per REQ-016 with IDLE, mdu_vld=0, wb_en=0, wb_addr=0, wb_data=0, mdu_srcA=mdu_srcB=0, counter=0, err=0.
REQ-022 Reset mid-operation (ISSUE/WAIT) SHALL abandon the op; a later mdu_o_vld for it SHALL be ignored per REQ-018.

Configuration
REQ-023 Macro SR_MDU_ISSUE_TIMEOUT_EN defined: in WAIT, counter reaching max_wait without mdu_o_vld -> next WB with wb_en suppressed, err set to 1 and held until reset.
REQ-024 Macro undefined: no timeout; WAIT persists until mdu_o_vld; err tied 0; counter may be omitted.

Verification
REQ-025 Basic: MDU latency 2, req with rd=5, srcA=7, srcB=6 at cycle 0 -> mdu_vld cycle 1, o_vld cycle 3, wb_en=1, wb_addr=5, wb_data=42 at cycle 4; stall high cycles 0-3, low cycle 4.
REQ-026 Busy backpressure: mdu_busy=1 cycles 1-3, then 0 -> mdu_vld single pulse at cycle 4; operands unchanged across cycles 1-4.
REQ-027 x0 dest: rd=0, srcA=3, srcB=4 -> full stall sequence, mdu_vld pulse, wb_en never asserted.
REQ-028 Back-to-back: two MULs (rd=1 5*5, rd=2 -1*2) -> two mdu_vld pulses, wb_data 25 then 32'hFFFFFFFE, no duplicate issue.
REQ-029 Reset in WAIT: rst low at cycle 2 of REQ-025 stimulus, req low after -> state IDLE, stall=0, o_vld at cycle 3 causes no wb_en.
REQ-030 Timeout (SR_MDU_ISSUE_TIMEOUT_EN, max_wait=4): o_vld never asserted -> WB after 4 WAIT cycles, wb_en=0, err=1 persisting; without macro stall stays high indefinitely.

Source files
------------

// File: rtl/sr_mdu_issue_if.sv
// Handshake bundle between the MUL issue controller (master) and the multiplier unit (slave).
interface sr_mdu_issue_if;
    logic        mdu_vld;
    logic [31:0] mdu_srcA;
    logic [31:0] mdu_srcB;
    logic        mdu_o_vld;
    logic [31:0] mdu_result;
    logic        mdu_busy;

    modport master (
        output mdu_vld, mdu_srcA, mdu_srcB,
        input  mdu_o_vld, mdu_result, mdu_busy
    );

    modport slave (
        input  mdu_vld, mdu_srcA, mdu_srcB,
        output mdu_o_vld, mdu_result, mdu_busy
    );
endinterface

// File: rtl/sr_mdu_issue.sv
// Stalls decode while a MUL is handed to the multiplier, then writes the product back.
// Optional WAIT timeout with sticky err is enabled by defining SR_MDU_ISSUE_TIMEOUT_EN.
module sr_mdu_issue #(
    parameter int max_wait = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [4:0]           rd,
    input  logic [31:0]          srcA,
    input  logic [31:0]          srcB,
    output logic                 stall,
    output logic                 wb_en,
    output logic [4:0]           wb_addr,
    output logic [31:0]          wb_data,
    output logic                 err,
    sr_mdu_issue_if.master       mdu
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    localparam logic [7:0] wait_limit = 8'(max_wait);

    state_t      state;
    state_t      state_next;
    logic [4:0]  rd_q;
    logic [31:0] src_a_q;
    logic [31:0] src_b_q;
    logic [31:0] result_q;
    logic [7:0]  wait_cnt;
    logic        accept;
    logic        issue;
    logic        capture;
    logic        timeout;
    logic        timed_out;
    logic        vld;

`ifdef SR_MDU_ISSUE_TIMEOUT_EN
    logic err_q;
    logic timed_out_q;

    assign timeout   = (state == WAIT) && !mdu.mdu_o_vld && (wait_cnt == wait_limit - 8'd1);
    assign timed_out = timed_out_q;
    assign err       = err_q;

    // err is sticky until reset; timed_out only masks the write-back of the current op
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q       <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            if (timeout) begin
                err_q       <= 1'b1;
                timed_out_q <= 1'b1;
            end else if (accept) begin
                timed_out_q <= 1'b0;
            end
        end
    end
`else
    assign timeout   = 1'b0;
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        vld        = 1'b0;
        wb_en      = 1'b0;
        accept     = 1'b0;
        issue      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    stall      = 1'b1;
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                stall = 1'b1;
                if (!mdu.mdu_busy) begin
                    vld        = 1'b1;
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mdu.mdu_o_vld) begin
                    capture    = 1'b1;
                    state_next = WB;
                end else if (timeout) begin
                    state_next = WB;
                end
            end
            WB: begin
                wb_en      = (rd_q != 5'd0) && !timed_out;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands change only on acceptance so the multiplier sees stable inputs for the whole op
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q     <= 5'd0;
            src_a_q  <= 32'd0;
            src_b_q  <= 32'd0;
            result_q <= 32'd0;
            wait_cnt <= 8'd0;
        end else begin
            if (accept) begin
                rd_q    <= rd;
                src_a_q <= srcA;
                src_b_q <= srcB;
            end
            if (capture) result_q <= mdu.mdu_result;
            if (issue) begin
                wait_cnt <= 8'd0;
            end else if (state == WAIT && !mdu.mdu_o_vld && wait_cnt != wait_limit) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign mdu.mdu_vld  = vld;
    assign mdu.mdu_srcA = src_a_q;
    assign mdu.mdu_srcB = src_b_q;
    assign wb_addr      = rd_q;
    assign wb_data      = result_q;

endmodule

// File: tb/tb_sr_mdu_issue.sv
// Directed self-checking bench for sr_mdu_issue; timeout scenario follows SR_MDU_ISSUE_TIMEOUT_EN.
module tb_sr_mdu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [4:0]  rd;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    sr_mdu_issue_if mdu_bus ();

    sr_mdu_issue #(.max_wait(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rd      (rd),
        .srcA    (srcA),
        .srcB    (srcB),
        .stall   (stall),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .err     (err),
        .mdu     (mdu_bus)
    );

    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic r, input logic [4:0] d, input logic [31:0] a,
                                  input logic [31:0] b, input logic ov, input logic [31:0] res,
                                  input logic busy);
        req                = r;
        rd                 = d;
        srcA               = a;
        srcB               = b;
        mdu_bus.mdu_o_vld  = ov;
        mdu_bus.mdu_result = res;
        mdu_bus.mdu_busy   = busy;
        #1;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic s, input logic v, input logic w);
        check_bit({tag, " stall"}, stall, s);
        check_bit({tag, " mdu_vld"}, mdu_bus.mdu_vld, v);
        check_bit({tag, " wb_en"}, wb_en, w);
    endtask

    initial begin
        // Reset state, including stall following req while held in IDLE
        rst = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_ctrl("reset", 0, 0, 0);
        check_output("reset wb_addr", {27'd0, wb_addr}, 32'd0);
        check_output("reset wb_data", wb_data, 32'd0);
        check_output("reset srcA", mdu_bus.mdu_srcA, 32'd0);
        check_output("reset srcB", mdu_bus.mdu_srcB, 32'd0);
        check_bit("reset err", err, 1'b0);
        apply_stimulus(1, 5, 7, 6, 0, 0, 0);
        check_ctrl("reset req", 1, 0, 0);
        next_cycle;
        rst = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_ctrl("idle", 0, 0, 0);

        // Basic: latency 2, 7*6 -> x5
        next_cycle; apply_stimulus(1, 5, 7, 6, 0, 0, 0);  check_ctrl("basic c0", 1, 0, 0);
        next_cycle; apply_stimulus(1, 5, 7, 6, 0, 0, 0);  check_ctrl("basic c1", 1, 1, 0);
        check_output("basic srcA", mdu_bus.mdu_srcA, 32'd7);
        check_output("basic srcB", mdu_bus.mdu_srcB, 32'd6);
        next_cycle; apply_stimulus(1, 5, 7, 6, 0, 0, 0);  check_ctrl("basic c2", 1, 0, 0);
        next_cycle; apply_stimulus(1, 5, 7, 6, 1, 42, 0); check_ctrl("basic c3", 1, 0, 0);
        next_cycle; apply_stimulus(1, 5, 7, 6, 0, 0, 0);  check_ctrl("basic c4", 0, 0, 1);
        check_output("basic wb_addr", {27'd0, wb_addr}, 32'd5);
        check_output("basic wb_data", wb_data, 32'd42);
        next_cycle; apply_stimulus(0, 0, 0, 0, 1, 99, 0); check_ctrl("basic c5", 0, 0, 0);
        next_cycle; apply_stimulus(0, 0, 0, 0, 0, 0, 0);  check_ctrl("idle o_vld", 0, 0, 0);
        check_output("idle o_vld wb_data", wb_data, 32'd42);

        // Busy backpressure with decode operands changing under a held stall
        next_cycle; apply_stimulus(1, 3, 10, 11, 0, 0, 0); check_ctrl("busy c0", 1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            next_cycle;
            apply_stimulus(1, 3, 32'hDEADBEEF, 32'hCAFEF00D, 0, 0, 1);
            check_ctrl("busy hold", 1, 0, 0);
            check_output("busy srcA", mdu_bus.mdu_srcA, 32'd10);
            check_output("busy srcB", mdu_bus.mdu_srcB, 32'd11);
        end
        next_cycle; apply_stimulus(1, 3, 10, 11, 0, 0, 0);   check_ctrl("busy c4", 1, 1, 0);
        check_output("busy c4 srcA", mdu_bus.mdu_srcA, 32'd10);
        next_cycle; apply_stimulus(1, 3, 10, 11, 1, 110, 0); check_ctrl("busy c5", 1, 0, 0);
        next_cycle; apply_stimulus(1, 3, 10, 11, 0, 0, 0);   check_ctrl("busy c6", 0, 0, 1);
        check_output("busy wb_addr", {27'd0, wb_addr}, 32'd3);
        check_output("busy wb_data", wb_data, 32'd110);
        next_cycle; apply_stimulus(0, 0, 0, 0, 0, 0, 0);     check_ctrl("busy c7", 0, 0, 0);

        // x0 destination: full sequence but no write
        next_cycle; apply_stimulus(1, 0, 3, 4, 0, 0, 0);  check_ctrl("x0 c0", 1, 0, 0);
        next_cycle; apply_stimulus(1, 0, 3, 4, 0, 0, 0);  check_ctrl("x0 c1", 1, 1, 0);
        next_cycle; apply_stimulus(1, 0, 3, 4, 1, 12, 0); check_ctrl("x0 c2", 1, 0, 0);
        next_cycle; apply_stimulus(1, 0, 3, 4, 0, 0, 0);  check_ctrl("x0 c3", 0, 0, 0);
        check_output("x0 wb_data", wb_data, 32'd12);
        check_output("x0 wb_addr", {27'd0, wb_addr}, 32'd0);
        next_cycle; apply_stimulus(0, 0, 0, 0, 0, 0, 0);  check_ctrl("x0 c4", 0, 0, 0);

        // Back-to-back MULs; req held through WB must not re-issue
        next_cycle; apply_stimulus(1, 1, 5, 5, 0, 0, 0);  check_ctrl("b2b c0", 1, 0, 0);
        next_cycle; apply_stimulus(1, 1, 5, 5, 0, 0, 0);  check_ctrl("b2b c1", 1, 1, 0);
        next_cycle; apply_stimulus(1, 1, 5, 5, 1, 25, 0); check_ctrl("b2b c2", 1, 0, 0);
        next_cycle; apply_stimulus(1, 1, 5, 5, 0, 0, 0);  check_ctrl("b2b c3", 0, 0, 1);
        check_output("b2b wb_addr1", {27'd0, wb_addr}, 32'd1);
        check_output("b2b wb_data1", wb_data, 32'd25);
        next_cycle; apply_stimulus(1, 2, 32'hFFFFFFFF, 2, 0, 0, 0); check_ctrl("b2b c4", 1, 0, 0);
        next_cycle; apply_stimulus(1, 2, 32'hFFFFFFFF, 2, 0, 0, 0); check_ctrl("b2b c5", 1, 1, 0);
        check_output("b2b srcA2", mdu_bus.mdu_srcA, 32'hFFFFFFFF);
        check_output("b2b srcB2", mdu_bus.mdu_srcB, 32'd2);
        next_cycle; apply_stimulus(1, 2, 32'hFFFFFFFF, 2, 1, 32'hFFFFFFFE, 0); check_ctrl("b2b c6", 1, 0, 0);
        next_cycle; apply_stimulus(1, 2, 32'hFFFFFFFF, 2, 0, 0, 0); check_ctrl("b2b c7", 0, 0, 1);
        check_output("b2b wb_addr2", {27'd0, wb_addr}, 32'd2);
        check_output("b2b wb_data2", wb_data, 32'hFFFFFFFE);
        next_cycle; apply_stimulus(0, 0, 0, 0, 0, 0, 0);  check_ctrl("b2b c8", 0, 0, 0);

        // Reset while waiting abandons the op; its late result is ignored
        next_cycle; apply_stimulus(1, 5, 7, 6, 0, 0, 0);  check_ctrl("rstw c0", 1, 0, 0);
        next_cycle; apply_stimulus(1, 5, 7, 6, 0, 0, 0);  check_ctrl("rstw c1", 1, 1, 0);
        next_cycle; rst = 1'b0;
        apply_stimulus(0, 5, 7, 6, 0, 0, 0);              check_ctrl("rstw c2", 0, 0, 0);
        check_output("rstw wb_addr", {27'd0, wb_addr}, 32'd0);
        check_output("rstw wb_data", wb_data, 32'd0);
        check_output("rstw srcA", mdu_bus.mdu_srcA, 32'd0);
        next_cycle; rst = 1'b1;
        apply_stimulus(0, 5, 7, 6, 1, 42, 0);             check_ctrl("rstw c3", 0, 0, 0);
        next_cycle; apply_stimulus(0, 0, 0, 0, 0, 0, 0);  check_ctrl("rstw c4", 0, 0, 0);
        check_output("rstw late wb_data", wb_data, 32'd0);

        // Multiplier that never answers
        next_cycle; apply_stimulus(1, 7, 2, 3, 0, 0, 0);  check_ctrl("to c0", 1, 0, 0);
        next_cycle; apply_stimulus(1, 7, 2, 3, 0, 0, 0);  check_ctrl("to c1", 1, 1, 0);
`ifdef SR_MDU_ISSUE_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            next_cycle; apply_stimulus(1, 7, 2, 3, 0, 0, 0); check_ctrl("to wait", 1, 0, 0);
            check_bit("to wait err", err, 1'b0);
        end
        next_cycle; apply_stimulus(1, 7, 2, 3, 0, 0, 0);  check_ctrl("to wb", 0, 0, 0);
        check_bit("to wb err", err, 1'b1);
        next_cycle; apply_stimulus(0, 0, 0, 0, 1, 6, 0);  check_ctrl("to late", 0, 0, 0);
        check_bit("to late err", err, 1'b1);
        next_cycle; apply_stimulus(0, 0, 0, 0, 0, 0, 0);  check_ctrl("to idle", 0, 0, 0);
        check_bit("to idle err", err, 1'b1);
        check_output("to wb_data", wb_data, 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            next_cycle; apply_stimulus(1, 7, 2, 3, 0, 0, 0); check_ctrl("nto wait", 1, 0, 0);
            check_bit("nto wait err", err, 1'b0);
        end
        next_cycle; apply_stimulus(1, 7, 2, 3, 1, 6, 0);  check_ctrl("nto ovld", 1, 0, 0);
        next_cycle; apply_stimulus(1, 7, 2, 3, 0, 0, 0);  check_ctrl("nto wb", 0, 0, 1);
        check_output("nto wb_data", wb_data, 32'd6);
        check_output("nto wb_addr", {27'd0, wb_addr}, 32'd7);
        check_bit("nto err", err, 1'b0);
        next_cycle; apply_stimulus(0, 0, 0, 0, 0, 0, 0);  check_ctrl("nto idle", 0, 0, 0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
